// File: rtl/prefetch_unit_if.sv
// Bus bundle for prefetch_unit: redirect, memory request/response, decode.
// master = prefetcher view, slave = core/memory environment view.
interface prefetch_unit_if #(
  parameter int Xlen     = 64,
  parameter int Ilen     = 32,
  parameter int MemWidth = 64
);
  logic                redirect_i;
  logic [Xlen-1:0]     redirect_pc_i;
  logic                mem_valid_o;
  logic                mem_ready_i;
  logic [Xlen-1:0]     mem_addr_o;
  logic                mem_rvalid_i;
  logic [MemWidth-1:0] mem_rdata_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [Xlen-1:0]     inst_pc_o;
  logic [Ilen-1:0]     inst_data_o;

  modport master (
    input  redirect_i, redirect_pc_i,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  inst_ready_i,
    output mem_valid_o, mem_addr_o,
    output inst_valid_o, inst_pc_o, inst_data_o
  );

  modport slave (
    output redirect_i, redirect_pc_i,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output inst_ready_i,
    input  mem_valid_o, mem_addr_o,
    input  inst_valid_o, inst_pc_o, inst_data_o
  );
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: issues aligned beats, buffers them, unpacks one
// instruction per cycle. Ports: clk_i, rst_ni (async low), bus (master).
module prefetch_unit #(
  parameter int              Xlen           = 64,
  parameter int              Ilen           = 32,
  parameter int              MemWidth       = 64,
  parameter int              MaxOutstanding = 2,
  parameter int              DepthLog2      = 2,
  parameter logic [Xlen-1:0] BootAddr       = Xlen'(64'h8000_0000)
) (
  input logic              clk_i,
  input logic              rst_ni,
  prefetch_unit_if.master  bus
);

  localparam int Ipb   = MemWidth / Ilen;
  localparam int Bpb   = MemWidth / 8;
  localparam int SlotW = (Ipb > 1) ? $clog2(Ipb) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam int Depth = 2 ** DepthLog2;
  localparam int QW    = DepthLog2 + 1;
  localparam logic [Xlen-1:0] AMask = ~Xlen'(Bpb - 1);

  function automatic logic [Xlen-1:0] align(
    input logic [Xlen-1:0] a
  );
    return a & AMask;
  endfunction

  function automatic logic [SlotW-1:0] slot_of(
    input logic [Xlen-1:0] a
  );
    logic [Xlen-1:0] w;
    w = (a >> 2) & Xlen'(Ipb - 1);
    return w[SlotW-1:0];
  endfunction

  typedef struct packed {
    logic [Xlen-1:0]     addr;
    logic [MemWidth-1:0] data;
    logic [SlotW-1:0]    start;
  } entry_t;

  entry_t               q_mem [Depth];
  logic [DepthLog2-1:0] wr_ptr_q;
  logic [DepthLog2-1:0] rd_ptr_q;
  logic [QW-1:0]        count_q;
  logic                 run_q;
  logic [CntW-1:0]      outst_q;
  logic [CntW-1:0]      drop_q;
  logic                 first_q;
  logic [SlotW-1:0]     start_off_q;
  logic [SlotW-1:0]     slot_q;
  logic [Xlen-1:0]      req_addr_q;
  logic [Xlen-1:0]      resp_addr_q;

  logic            redirect;
  logic [Xlen-1:0] target;
  logic            credit_ok;
  logic            accept;
  logic            rvalid;
  logic            push;
  logic            fire;
  logic            pop;
  entry_t          head;
  logic [SlotW-1:0] s;

  assign redirect = bus.redirect_i;
  assign target   = align(bus.redirect_pc_i);
  assign rvalid   = bus.mem_rvalid_i;

  // A redirect flushes everything fresh, so the credit is trivially there.
  always_comb begin
    credit_ok = 1'b0;
    if (redirect) begin
      credit_ok = 1'b1;
    end else begin
      credit_ok = (int'(outst_q - drop_q) + int'(count_q)) < Depth;
    end
  end

  assign bus.mem_valid_o = run_q
                         && (int'(outst_q) < MaxOutstanding)
                         && credit_ok;
  assign bus.mem_addr_o  = redirect ? target : req_addr_q;
  assign accept = bus.mem_valid_o && bus.mem_ready_i;

  // Stale beats and any beat landing with a redirect are discarded.
  assign push = rvalid && (drop_q == '0) && !redirect;

  assign head = q_mem[rd_ptr_q];
  assign s    = (slot_q > head.start) ? slot_q : head.start;

  assign bus.inst_valid_o = (count_q != '0) && !redirect;
  assign bus.inst_data_o  = head.data[int'(s)*Ilen +: Ilen];
  assign bus.inst_pc_o    = head.addr + (Xlen'(s) << 2);

  assign fire = bus.inst_valid_o && bus.inst_ready_i;
  assign pop  = fire && (int'(s) == Ipb - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      outst_q     <= '0;
      drop_q      <= '0;
      first_q     <= 1'b1;
      start_off_q <= slot_of(BootAddr);
      req_addr_q  <= align(BootAddr);
      resp_addr_q <= align(BootAddr);
    end else begin
      run_q   <= 1'b1;
      outst_q <= outst_q + CntW'(accept) - CntW'(rvalid);

      if (redirect) begin
        drop_q <= outst_q - CntW'(rvalid);
      end else if (rvalid && (drop_q != '0)) begin
        drop_q <= drop_q - CntW'(1);
      end

      if (redirect) begin
        first_q     <= 1'b1;
        start_off_q <= slot_of(bus.redirect_pc_i);
        resp_addr_q <= target;
      end else if (push) begin
        first_q     <= 1'b0;
        resp_addr_q <= resp_addr_q + Xlen'(Bpb);
      end

      if (accept) begin
        req_addr_q <= bus.mem_addr_o + Xlen'(Bpb);
      end else if (redirect) begin
        req_addr_q <= target;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slot_q   <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slot_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        slot_q   <= '0;
      end else if (fire) begin
        slot_q <= s + SlotW'(1);
      end
      count_q <= count_q + QW'(push) - QW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        q_mem[i] <= '0;
      end
    end else if (push) begin
      q_mem[wr_ptr_q] <= '{
        addr:  resp_addr_q,
        data:  bus.mem_rdata_i,
        start: first_q ? start_off_q : '0
      };
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized scoreboard bench for prefetch_unit with an in-bench memory
// model and a sequential-PC reference stream.
module tb_prefetch_unit;

  localparam int          MaxO = 2;
  localparam logic [63:0] Boot = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prefetch_unit_if #(
    .Xlen(64), .Ilen(32), .MemWidth(64)
  ) bus ();

  prefetch_unit #(
    .Xlen(64), .Ilen(32), .MemWidth(64),
    .MaxOutstanding(MaxO), .DepthLog2(2),
    .BootAddr(Boot)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678 ^ a[63:32];
  endfunction

  function automatic logic [63:0] beat_at(input logic [63:0] a);
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  function automatic logic [63:0] al8(input logic [63:0] a);
    return a & ~64'd7;
  endfunction

  // Reference: after a (re)start, decode must see pc, pc+4, pc+8, ...
  logic [63:0] exp_q[$];

  function automatic void start_stream(input logic [63:0] pc);
    exp_q.delete();
    for (int i = 0; i < 400; i++) exp_q.push_back(pc + 64'(4 * i));
  endfunction

  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int ready_pct = 100;
  int o_cnt = 0;
  int acc_cnt = 0;
  int hs_cnt = 0;
  int first_rv = -1;
  int first_iv = -1;

  typedef struct {
    logic [63:0] addr;
    int          rdy;
  } mreq_t;

  mreq_t mq[$];

  // Memory model: in-order responses, random latency >= 1, random ready.
  initial begin : mem_model
    int          last_rdy;
    logic [63:0] nxt;
    logic [63:0] ea;
    bit          acc;
    mreq_t       r;
    last_rdy = 0;
    nxt = Boot;
    bus.mem_ready_i  = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        o_cnt = 0;
        last_rdy = 0;
        nxt = Boot;
      end else begin
        acc = bus.mem_valid_o && bus.mem_ready_i;
        chk(o_cnt <= MaxO, "outst_limit", 64'(o_cnt), 64'(MaxO));
        if (o_cnt == MaxO)
          chk(!bus.mem_valid_o, "valid_at_limit",
              64'(bus.mem_valid_o), 64'd0);
        ea = bus.redirect_i ? al8(bus.redirect_pc_i) : nxt;
        if (acc) begin
          chk(bus.mem_addr_o == ea, "req_addr", bus.mem_addr_o, ea);
          nxt = ea + 64'd8;
          acc_cnt++;
          r.addr = ea;
          r.rdy  = cyc + $urandom_range(lat_max, lat_min);
          if (r.rdy < last_rdy) r.rdy = last_rdy;
          last_rdy = r.rdy;
          mq.push_back(r);
        end else if (bus.redirect_i) begin
          nxt = ea;
        end
        o_cnt = o_cnt + int'(acc) - int'(bus.mem_rvalid_i);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        mq.delete();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_ready_i  = 1'b0;
      end else begin
        bus.mem_ready_i = ($urandom_range(99) < ready_pct);
        if (mq.size() != 0 && mq[0].rdy <= cyc) begin
          r = mq.pop_front();
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = beat_at(r.addr);
        end else begin
          bus.mem_rvalid_i = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the reference stream on every decode handshake.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        first_rv = -1;
        first_iv = -1;
      end else begin
        if (bus.mem_rvalid_i && first_rv < 0) first_rv = cyc;
        if (bus.inst_valid_o && first_iv < 0) first_iv = cyc;
        if (bus.redirect_i)
          chk(!bus.inst_valid_o, "valid_gated",
              64'(bus.inst_valid_o), 64'd0);
        if (bus.inst_valid_o && bus.inst_ready_i) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "sb_empty", bus.inst_pc_o, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(bus.inst_pc_o == e, "inst_pc", bus.inst_pc_o, e);
            chk(bus.inst_data_o == word_at(e), "inst_data",
                64'(bus.inst_data_o), 64'(word_at(e)));
          end
        end
      end
    end
  end

  task automatic do_redirect(input logic [63:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    start_stream(pc);
    @(posedge clk);
    #1;
    bus.redirect_i = 1'b0;
  endtask

  task automatic wait_full(output bit found, input bit need_rv);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #2;
      if (o_cnt == MaxO && (!need_rv || bus.mem_rvalid_i))
        found = 1'b1;
    end
  endtask

  initial begin : main
    int          h0;
    int          a0;
    int          len;
    int          ir_pct;
    bit          found;
    logic [63:0] pc;
    rst_n = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.inst_ready_i  = 1'b1;
    start_stream(Boot);
    repeat (3) @(negedge clk);
    chk(!bus.mem_valid_o, "rst_mem_valid", 64'(bus.mem_valid_o), 0);
    chk(!bus.inst_valid_o, "rst_inst_valid", 64'(bus.inst_valid_o), 0);
    chk(bus.mem_addr_o == Boot, "rst_mem_addr", bus.mem_addr_o, Boot);
    #2 rst_n = 1'b1;

    // Boot with ideal memory: full rate, one-cycle response-to-decode.
    repeat (12) @(posedge clk);
    #1;
    h0 = hs_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk(hs_cnt - h0 == 20, "throughput", 64'(hs_cnt - h0), 64'd20);
    chk(first_rv >= 0, "first_rvalid_seen", 64'(first_rv), 0);
    chk(first_iv == first_rv + 1, "first_latency",
        64'(first_iv - first_rv), 64'd1);

    // Unaligned redirect with two requests in flight.
    lat_min = 3;
    lat_max = 3;
    wait_full(found, 1'b0);
    chk(found, "wait_outst2", 64'(o_cnt), 64'(MaxO));
    do_redirect(64'h8000_0104);
    h0 = hs_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk(hs_cnt > h0, "progress_unaligned", 64'(hs_cnt - h0), 64'd1);

    // Redirect coincident with a response while outstanding is full.
    wait_full(found, 1'b1);
    chk(found, "wait_rv_full", 64'(o_cnt), 64'(MaxO));
    do_redirect(64'h8000_200C);
    h0 = hs_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk(hs_cnt > h0, "progress_coincident", 64'(hs_cnt - h0), 64'd1);

    // Backpressure: decode stalls for 20 cycles.
    lat_min = 1;
    lat_max = 1;
    do_redirect(64'h8000_3000);
    repeat (5) @(posedge clk);
    #1;
    bus.inst_ready_i = 1'b0;
    repeat (10) @(posedge clk);
    a0 = acc_cnt;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(!bus.mem_valid_o, "bp_mem_valid", 64'(bus.mem_valid_o), 0);
    chk(bus.inst_valid_o, "bp_inst_valid", 64'(bus.inst_valid_o), 1);
    chk(acc_cnt == a0, "bp_no_issue", 64'(acc_cnt - a0), 0);
    @(posedge clk);
    #1;
    bus.inst_ready_i = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    // Address wrap at the top of the space.
    do_redirect(64'hFFFF_FFFF_FFFF_FFF4);
    repeat (20) @(posedge clk);
    #1;

    // Randomized traffic with redirects, some back to back.
    for (int seg = 0; seg < 30; seg++) begin
      lat_min   = $urandom_range(2, 1);
      lat_max   = lat_min + $urandom_range(3, 0);
      ready_pct = $urandom_range(100, 30);
      ir_pct    = $urandom_range(100, 40);
      len       = $urandom_range(60, 10);
      repeat (len) begin
        @(posedge clk);
        #1;
        bus.inst_ready_i = ($urandom_range(99) < ir_pct);
      end
      pc = 64'h8000_0000 + 64'($urandom_range(16383, 0)) * 64'd4;
      do_redirect(pc);
      if ($urandom_range(3, 0) == 0) begin
        pc = 64'h9000_0000 + 64'($urandom_range(16383, 0)) * 64'd4;
        do_redirect(pc);
      end
    end

    // Asynchronous reset mid-stream with full outstanding.
    lat_min = 3;
    lat_max = 3;
    ready_pct = 100;
    bus.inst_ready_i = 1'b1;
    wait_full(found, 1'b0);
    chk(found, "wait_rst_outst", 64'(o_cnt), 64'(MaxO));
    #1;
    rst_n = 1'b0;
    start_stream(Boot);
    #1;
    chk(!bus.mem_valid_o, "mid_rst_mem_valid", 64'(bus.mem_valid_o), 0);
    chk(!bus.inst_valid_o, "mid_rst_inst_valid",
        64'(bus.inst_valid_o), 0);
    chk(bus.mem_addr_o == Boot, "mid_rst_addr", bus.mem_addr_o, Boot);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    h0 = hs_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk(hs_cnt - h0 > 5, "progress_after_rst", 64'(hs_cnt - h0), 64'd6);
    chk(hs_cnt > 200, "total_handshakes", 64'(hs_cnt), 64'd201);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetcher that sits between the core's instruction memory port and decode. It issues aligned memory beats of `MemWidth` bits with up to `MaxOutstanding` requests in flight and buffers returned beats. It unpacks each beat into one `Ilen`-bit instruction per cycle for decode. On a redirect it flushes the buffer, squashes in-flight responses by count, and drops leading instructions when the target is not beat-aligned.

## Interface
- `Xlen`, 64: address / PC width.
- `Ilen`, 32: instruction width. Fixed at 32; no compressed support.
- `MemWidth`, 64: memory data width. Legal values: 32, 64, 128, 256. `Ipb = MemWidth/Ilen`; `Bpb = MemWidth/8` bytes per beat.
- `MaxOutstanding`, 2: in-flight request limit. Range 1..7.
- `DepthLog2`, 2: beat queue holds `2**DepthLog2` entries.
- `BootAddr`, 64'h8000_0000: first fetch PC. Must be 4-byte aligned.
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `redirect_i`, in, 1: flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`, in, Xlen: new PC. 4-byte aligned.
- `mem_valid_o`, out, 1: request valid.
- `mem_ready_i`, in, 1: memory accepts the request.
- `mem_addr_o`, out, Xlen: request address, `Bpb`-aligned.
- `mem_rvalid_i`, in, 1: response beat valid. Responses arrive in order, one per accepted request, at least 1 cycle after acceptance. No backpressure on responses.
- `mem_rdata_i`, in, MemWidth: response data. Instruction k occupies bits `[k*32 +: 32]`.
- `inst_valid_o`, out, 1: instruction valid.
- `inst_ready_i`, in, 1: decode accepts the instruction.
- `inst_pc_o`, out, Xlen: PC of the presented instruction.
- `inst_data_o`, out, Ilen: instruction word.

## Operation
- **State:**
  - `req_addr_q`: next beat address.
  - `outst_q`: accepted requests not yet responded, width `$clog2(MaxOutstanding+1)`.
  - `drop_q`: stale responses still to discard. Invariant `drop_q <= outst_q`.
  - `first_q`, `start_off_q`: the next fresh response starts at slot `start_off_q`.
  - Beat queue: each entry is {beat addr, data, start slot}.
  - `slot_q`: read slot within the head entry.
  - `run_q`: cleared by reset, set 1 cycle after release.
- **Issue rule:**
  - `mem_valid_o = run_q && outst_q < MaxOutstanding && (outst_q - drop_q) + count < 2**DepthLog2`. This credit check guarantees every fresh response finds a free entry; overflow is impossible.
  - `mem_addr_o = redirect_i ? align(redirect_pc_i) : req_addr_q`.
  - On acceptance, `req_addr_q <= mem_addr_o + Bpb`.
  - On a redirect without acceptance, `req_addr_q <= align(redirect_pc_i)`.
  - In a redirect cycle the credit check uses post-flush values: count 0 and fresh outstanding 0.
- **Response handling:**
  - `rvalid` with `drop_q > 0`, or coincident with `redirect_i`: discard the beat.
  - Otherwise push {resp addr, data, `first_q ? start_off_q : 0`} and clear `first_q`.
  - The response address is tracked by a register advanced by `Bpb` per fresh push. It is reloaded with `align(target)` on redirect.
- **Redirect:**
  - Queue count and `slot_q` clear.
  - `drop_q <= outst_q - rvalid_i`.
  - `first_q <= 1`, `start_off_q <= redirect_pc_i[$clog2(Bpb)-1:2]`.
  - `outst_q` still tracks all requests: `+accept - rvalid`.
- **Output:**
  - Head entry slot s = `max(slot_q, entry start)`.
  - `inst_data_o` = data slot s.
  - `inst_pc_o = beat addr + 4*s`.
  - On handshake, if `s == Ipb-1` pop and set `slot_q <= 0`; else `slot_q <= s+1`.
  - The output is gated low during a redirect cycle (`inst_valid_o = count != 0 && !redirect_i`).
- **Reset** (async): `run_q=0`, `outst_q=0`, `drop_q=0`, queue empty, `slot_q=0`, `req_addr_q=align(BootAddr)`, `first_q=1`, `start_off_q` = BootAddr slot. Outputs during reset: `mem_valid_o=0`, `inst_valid_o=0`, `mem_addr_o=align(BootAddr)`.
- **Address arithmetic:** modulo `2**Xlen`; wrap is silent.

## Timing
- **Latency:** earliest `inst_valid_o` is the cycle after the first fresh `rvalid`. Response to decode takes 1 cycle.
- **Throughput:** one instruction per cycle when fed.
- **Redirect:**
  - The request for the target is issued in the same cycle as the redirect.
  - A redirect with full outstanding issues only once `outst_q` drops.
  - Back-to-back redirects: the last one wins, and `drop_q` accumulates correctly.
- **Boundary cases:**
  - Queue full and head popped with a push in the same cycle: both take effect.
  - A redirect coincident with a pop: the flush dominates.
  - `MaxOutstanding=1`: at most 1 beat per 2 cycles.

## Test plan
1. **Boot, ideal memory:** `MemWidth=64`, 1-cycle latency, `inst_ready` always high. Expect PCs 0x8000_0000, 0x8000_0004, 0x8000_0008… consecutive, with `mem_addr_o` stepping by 8.
2. **Unaligned redirect:** redirect to 0x8000_0104 with 2 outstanding. Expect exactly 2 beats discarded; first output PC 0x8000_0104 with the upper word of beat 0x8000_0100, then 0x8000_0108.
3. **Redirect coincident with `rvalid`** and with `outst_q=2`. Expect `drop_q`=1, the coincident beat never appears, and no stale PC ever reaches decode.
4. **Backpressure:** `inst_ready=0` for 20 cycles, `DepthLog2=2`. Expect `mem_valid_o` to fall once outstanding plus count reaches 4, no beat to be lost, and in-order output resuming on release.
5. **Outstanding limit:** memory latency 3, `MaxOutstanding=2`. Expect `outst_q` never to exceed 2 and `mem_valid_o` to be low whenever `outst_q=2`.
6. **Reset mid-stream:** assert `rst_ni` low asynchronously mid-stream with 2 requests in flight. Expect outputs low immediately; after release, the first request is at `align(BootAddr)` and late responses from before reset are ignored (memory model also reset).
